irq_pending_ctrl: RTL

- Interrupt front end that sits directly upstream of the 8-to-3 priority encoder `priorityen`.
- Detects rising edges on 8 request lines and latches them into a pending register, then presents the masked pending vector to the encoder.
- Captures the encoder's index and issues it to the CPU side with a valid/ack handshake.
- Clears the serviced pending bit on acknowledge.

---
 rtl/irq_pending_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: interrupt front end for the 8-to-3 priority encoder.
// Detects rising edges on the request lines, latches them as pending,
// presents the masked pending vector to the encoder and offers the
// winning index to the CPU with a valid/ack handshake.
// Optional build macro: IRQ_OVERRUN_CNT_EN (lost-edge counter).
module irq_pending_ctrl #(
  parameter int N    = 8,  // encoder is fixed at 8 inputs; only 8 is supported
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    irq_in,
  input  logic [N-1:0]    mask,
  output logic [N-1:0]    enc_din,
  output logic            enc_en,
  input  logic [IDXW-1:0] enc_y,
  output logic            irq_valid,
  output logic [IDXW-1:0] irq_id,
  input  logic            irq_ack,
  output logic [N-1:0]    pending,
  output logic [7:0]      overrun_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [N-1:0]    r_irq_prev;
  logic [N-1:0]    r_pending;
  logic [0:0]      r_state;
  logic            r_irq_valid;
  logic [IDXW-1:0] r_irq_id;

  logic [N-1:0]    w_rise;
  logic [N-1:0]    w_clr;
  logic [N-1:0]    w_masked;
  logic            w_any_masked;

  assign w_rise       = irq_in & ~r_irq_prev;
  assign w_masked     = r_pending & ~mask;
  assign w_any_masked = |w_masked;

  // One-hot clear of the offered bit; masking does not block the clear.
  always_comb begin
    w_clr = '0;
    if (r_state == ST_WAIT && irq_ack) begin
      w_clr[r_irq_id] = 1'b1;
    end
  end

  // Previous-cycle request sample for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_prev <= '0;
    end else begin
      r_irq_prev <= irq_in;
    end
  end

  // Pending register: a new edge wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_rise | (r_pending & ~w_clr);
    end
  end

  // Offer FSM: arbitrate only in IDLE, hold the offer until acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_irq_valid <= 1'b0;
      r_irq_id    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_masked) begin
            r_irq_id    <= enc_y;
            r_irq_valid <= 1'b1;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (irq_ack) begin
            r_irq_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_irq_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign enc_din   = w_masked;
  assign enc_en    = (r_state == ST_IDLE);
  assign irq_valid = r_irq_valid;
  assign irq_id    = r_irq_id;
  assign pending   = r_pending;

`ifdef IRQ_OVERRUN_CNT_EN
  logic       w_overrun;
  logic [7:0] r_overrun_cnt;

  // An edge landing on a still-pending bit (not cleared now) is lost.
  assign w_overrun = |(w_rise & r_pending & ~w_clr);

  // Saturating lost-edge counter; several losses in one cycle count once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun_cnt <= 8'd0;
    end else if (w_overrun && (r_overrun_cnt != 8'hFF)) begin
      r_overrun_cnt <= r_overrun_cnt + 8'd1;
    end
  end

  assign overrun_cnt = r_overrun_cnt;
`else
  assign overrun_cnt = 8'd0;
`endif

endmodule
